// File: rtl/ifft_pkg.sv
// ifft_pkg: constants and helpers shared by the 8-point IFFT core and its
// output-side blocks.
//   IFFT_N / LOG2N      : transform size and index width
//   DEF_IN_W/DEF_OUT_W  : default sample widths on the core and DAC sides
//   DEF_SHIFT           : default post-IFFT down-scaling shift
//   bitrev3()           : 3-bit index bit reversal used by the radix-2 core
package ifft_pkg;

  localparam int IFFT_N    = 8;
  localparam int LOG2N     = 3;
  localparam int DEF_IN_W  = 16;
  localparam int DEF_OUT_W = 12;
  localparam int DEF_SHIFT = 3;

  typedef logic [LOG2N-1:0] idx_t;

  function automatic idx_t bitrev3(input idx_t v);
    idx_t r;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = v[LOG2N-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ifft_round_sat.sv
// ifft_round_sat: combinational round-half-up, arithmetic right shift and
// saturation of one signed sample component.
//   x   : IN_W-bit signed input sample
//   y   : OUT_W-bit signed scaled and saturated result
//   sat : high when the shifted value fell outside the OUT_W range
module ifft_round_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 12,
  parameter int SHIFT = 3
) (
  input  logic [IN_W-1:0]  x,
  output logic [OUT_W-1:0] y,
  output logic             sat
);

  // One guard bit keeps x + half from wrapping at the positive full scale.
  localparam int TW = IN_W + 1;
  localparam logic signed [TW-1:0] MAX_V = TW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [TW-1:0] MIN_V = ~MAX_V;

  logic signed [TW-1:0] x_ext;
  logic signed [TW-1:0] t;

  assign x_ext = {x[IN_W-1], x};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [TW-1:0] HALF = TW'(1 << (SHIFT - 1));
      assign t = (x_ext + HALF) >>> SHIFT;
    end else begin : g_pass
      assign t = x_ext;
    end
  endgenerate

  always_comb begin
    y   = t[OUT_W-1:0];
    sat = 1'b0;
    if (t > MAX_V) begin
      y   = MAX_V[OUT_W-1:0];
      sat = 1'b1;
    end else if (t < MIN_V) begin
      y   = MIN_V[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/ifft_out_reorder_serializer.sv
// ifft_out_reorder_serializer: captures 8-sample parallel IFFT frames (in
// bit-reversed position order) into a two-frame ping-pong buffer and streams
// them out one complex sample per beat in natural order, scaled to OUT_W.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid          : one-cycle frame strobe from the core
//   in{p}_i / in{p}_q : frame samples, position p holds natural index bitrev3(p)
//   m_valid / m_ready : output handshake
//   m_i, m_q          : scaled sample; m_index natural index; m_last index 7
//   m_sat             : I or Q of this beat saturated
//   frame_drop        : pulse when a frame arrives with no free buffer
//   busy              : any buffer full or output valid
module ifft_out_reorder_serializer
  import ifft_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in0_i,
  input  logic [IN_W-1:0]  in0_q,
  input  logic [IN_W-1:0]  in1_i,
  input  logic [IN_W-1:0]  in1_q,
  input  logic [IN_W-1:0]  in2_i,
  input  logic [IN_W-1:0]  in2_q,
  input  logic [IN_W-1:0]  in3_i,
  input  logic [IN_W-1:0]  in3_q,
  input  logic [IN_W-1:0]  in4_i,
  input  logic [IN_W-1:0]  in4_q,
  input  logic [IN_W-1:0]  in5_i,
  input  logic [IN_W-1:0]  in5_q,
  input  logic [IN_W-1:0]  in6_i,
  input  logic [IN_W-1:0]  in6_q,
  input  logic [IN_W-1:0]  in7_i,
  input  logic [IN_W-1:0]  in7_q,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_i,
  output logic [OUT_W-1:0] m_q,
  output logic [2:0]       m_index,
  output logic             m_last,
  output logic             m_sat,
  output logic             frame_drop,
  output logic             busy
);

  localparam idx_t IDX_LAST = idx_t'(IFFT_N - 1);

  logic [IN_W-1:0]   frame_i [IFFT_N];
  logic [IN_W-1:0]   frame_q [IFFT_N];
  logic [2*IN_W-1:0] frame_word [IFFT_N];

  assign frame_i[0] = in0_i;
  assign frame_i[1] = in1_i;
  assign frame_i[2] = in2_i;
  assign frame_i[3] = in3_i;
  assign frame_i[4] = in4_i;
  assign frame_i[5] = in5_i;
  assign frame_i[6] = in6_i;
  assign frame_i[7] = in7_i;
  assign frame_q[0] = in0_q;
  assign frame_q[1] = in1_q;
  assign frame_q[2] = in2_q;
  assign frame_q[3] = in3_q;
  assign frame_q[4] = in4_q;
  assign frame_q[5] = in5_q;
  assign frame_q[6] = in6_q;
  assign frame_q[7] = in7_q;

  // Stored word layout: Q in the upper half, I in the lower half.
  generate
    for (genvar gi = 0; gi < IFFT_N; gi++) begin : g_pack
      assign frame_word[gi] = {frame_q[gi], frame_i[gi]};
    end
  endgenerate

  // Two frame buffers, stored in arrival (bit-reversed) position order.
  logic [2*IN_W-1:0] buf_mem [2][IFFT_N];

  logic [1:0]       full_reg, full_next;
  logic             wr_sel_reg, wr_sel_next;
  logic             rd_sel_reg, rd_sel_next;
  idx_t             n_reg, n_next;
  logic             m_valid_reg, m_valid_next;
  logic [OUT_W-1:0] m_i_reg, m_i_next;
  logic [OUT_W-1:0] m_q_reg, m_q_next;
  idx_t             m_index_reg, m_index_next;
  logic             m_last_reg, m_last_next;
  logic             m_sat_reg, m_sat_next;
  logic             frame_drop_reg, frame_drop_next;

  logic             capture;
  logic             load;
  logic [2*IN_W-1:0] rd_word;
  logic [OUT_W-1:0] rs_i, rs_q;
  logic             sat_i, sat_q;

  // Uses the pre-edge full flag, so a buffer freed this cycle is not reused yet.
  assign capture = in_valid && !full_reg[wr_sel_reg];
  assign load    = full_reg[rd_sel_reg] && (!m_valid_reg || m_ready);

  always_ff @(posedge clk) begin
    if (capture) begin
      for (int k = 0; k < IFFT_N; k++) begin
        buf_mem[wr_sel_reg][k] <= frame_word[k];
      end
    end
  end

  // Natural index n lives at bit-reversed position n.
  assign rd_word = buf_mem[rd_sel_reg][bitrev3(n_reg)];

  ifft_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_rs_i (
    .x   (rd_word[IN_W-1:0]),
    .y   (rs_i),
    .sat (sat_i)
  );

  ifft_round_sat #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_rs_q (
    .x   (rd_word[2*IN_W-1:IN_W]),
    .y   (rs_q),
    .sat (sat_q)
  );

  always_comb begin
    full_next       = full_reg;
    wr_sel_next     = wr_sel_reg;
    rd_sel_next     = rd_sel_reg;
    n_next          = n_reg;
    m_valid_next    = m_valid_reg;
    m_i_next        = m_i_reg;
    m_q_next        = m_q_reg;
    m_index_next    = m_index_reg;
    m_last_next     = m_last_reg;
    m_sat_next      = m_sat_reg;
    frame_drop_next = in_valid && full_reg[wr_sel_reg];

    if (load) begin
      m_valid_next = 1'b1;
      m_i_next     = rs_i;
      m_q_next     = rs_q;
      m_index_next = n_reg;
      m_last_next  = (n_reg == IDX_LAST);
      m_sat_next   = sat_i | sat_q;
      if (n_reg == IDX_LAST) begin
        full_next[rd_sel_reg] = 1'b0;
        rd_sel_next           = ~rd_sel_reg;
        n_next                = '0;
      end else begin
        n_next = n_reg + idx_t'(1);
      end
    end else if (m_valid_reg && m_ready) begin
      m_valid_next = 1'b0;
    end

    // Capture and free never target the same buffer, so both apply.
    if (capture) begin
      full_next[wr_sel_reg] = 1'b1;
      wr_sel_next           = ~wr_sel_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg       <= '0;
      wr_sel_reg     <= 1'b0;
      rd_sel_reg     <= 1'b0;
      n_reg          <= '0;
      m_valid_reg    <= 1'b0;
      m_i_reg        <= '0;
      m_q_reg        <= '0;
      m_index_reg    <= '0;
      m_last_reg     <= 1'b0;
      m_sat_reg      <= 1'b0;
      frame_drop_reg <= 1'b0;
    end else begin
      full_reg       <= full_next;
      wr_sel_reg     <= wr_sel_next;
      rd_sel_reg     <= rd_sel_next;
      n_reg          <= n_next;
      m_valid_reg    <= m_valid_next;
      m_i_reg        <= m_i_next;
      m_q_reg        <= m_q_next;
      m_index_reg    <= m_index_next;
      m_last_reg     <= m_last_next;
      m_sat_reg      <= m_sat_next;
      frame_drop_reg <= frame_drop_next;
    end
  end

  assign m_valid    = m_valid_reg;
  assign m_i        = m_i_reg;
  assign m_q        = m_q_reg;
  assign m_index    = m_index_reg;
  assign m_last     = m_last_reg;
  assign m_sat      = m_sat_reg;
  assign frame_drop = frame_drop_reg;
  assign busy       = (|full_reg) | m_valid_reg;

endmodule

// File: tb/tb_ifft_out_reorder_serializer.sv
// tb_ifft_out_reorder_serializer: self-checking bench for the IFFT output
// reorder/serializer. A cycle-level reference model keeps the expected beat
// stream as a queue of natural-order samples; fixed tables cover reorder,
// rounding and saturation, hand sequences cover backpressure, ping-pong drop
// and mid-stream reset, and a random phase mixes strobes and backpressure.
module tb_ifft_out_reorder_serializer;

  localparam int IN_W  = 16;
  localparam int OUT_W = 12;
  localparam int SHIFT = 3;

  logic                   clk;
  logic                   rst_n;
  logic                   in_valid;
  logic                   m_ready;
  logic [IN_W-1:0]        in_i [8];
  logic [IN_W-1:0]        in_q [8];
  logic                   m_valid;
  logic signed [OUT_W-1:0] m_i;
  logic signed [OUT_W-1:0] m_q;
  logic [2:0]             m_index;
  logic                   m_last;
  logic                   m_sat;
  logic                   frame_drop;
  logic                   busy;

  ifft_out_reorder_serializer #(
    .IN_W (IN_W), .OUT_W (OUT_W), .SHIFT (SHIFT)
  ) dut (
    .clk (clk), .rst_n (rst_n), .in_valid (in_valid),
    .in0_i (in_i[0]), .in0_q (in_q[0]), .in1_i (in_i[1]), .in1_q (in_q[1]),
    .in2_i (in_i[2]), .in2_q (in_q[2]), .in3_i (in_i[3]), .in3_q (in_q[3]),
    .in4_i (in_i[4]), .in4_q (in_q[4]), .in5_i (in_i[5]), .in5_q (in_q[5]),
    .in6_i (in_i[6]), .in6_q (in_q[6]), .in7_i (in_i[7]), .in7_q (in_q[7]),
    .m_valid (m_valid), .m_ready (m_ready), .m_i (m_i), .m_q (m_q),
    .m_index (m_index), .m_last (m_last), .m_sat (m_sat),
    .frame_drop (frame_drop), .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
    int idx;
    bit last;
    bit sat;
  } beat_t;

  typedef struct {
    int x_i;
    int x_q;
    int e_i;
    int e_q;
    bit e_sat;
  } vec_t;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    hs_cnt  = 0;
  int    drop_cnt = 0;
  int    nat_i [8];
  int    nat_q [8];
  beat_t mq [$];
  beat_t cur;
  bit    mv = 1'b0;
  bit    exp_drop = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int brev(input int p);
    return ((p & 1) << 2) | (p & 2) | ((p >> 2) & 1);
  endfunction

  // Round half up by 2^SHIFT, on a wide signed integer.
  function automatic int scaled(input int x);
    int t;
    t = x;
    if (SHIFT > 0) t = (x + (1 << (SHIFT - 1))) >>> SHIFT;
    return t;
  endfunction

  function automatic int clampv(input int t);
    int hi;
    hi = (1 << (OUT_W - 1)) - 1;
    if (t > hi) return hi;
    if (t < -hi - 1) return -hi - 1;
    return t;
  endfunction

  function automatic bit oor(input int t);
    return clampv(t) != t;
  endfunction

  // Natural-order frame in nat_*; position p of the bus carries index brev(p).
  task automatic drive_frame();
    for (int p = 0; p < 8; p++) begin
      in_i[p] = IN_W'(nat_i[brev(p)]);
      in_q[p] = IN_W'(nat_q[brev(p)]);
    end
  endtask

  task automatic rand_frame();
    for (int n = 0; n < 8; n++) begin
      nat_i[n] = $signed(16'($urandom));
      nat_q[n] = $signed(16'($urandom));
    end
    drive_frame();
  endtask

  task automatic zero_frame(input int i0, input int q0);
    for (int n = 0; n < 8; n++) begin
      nat_i[n] = 0;
      nat_q[n] = 0;
    end
    nat_i[0] = i0;
    nat_q[0] = q0;
    drive_frame();
  endtask

  task automatic push_frame();
    beat_t b;
    for (int n = 0; n < 8; n++) begin
      b.i    = clampv(scaled(nat_i[n]));
      b.q    = clampv(scaled(nat_q[n]));
      b.idx  = n;
      b.last = (n == 7);
      b.sat  = oor(scaled(nat_i[n])) | oor(scaled(nat_q[n]));
      mq.push_back(b);
    end
  endtask

  // One clock: apply inputs, advance the model across the edge, compare.
  task automatic step(input bit v, input bit r);
    int held;
    bit acc;
    bit hs;
    bit ld;
    in_valid = v;
    m_ready  = r;
    @(posedge clk);
    held = (mq.size() + 7) / 8;
    acc  = v && (held < 2);
    hs   = mv && r;
    ld   = (mq.size() > 0) && (!mv || r);
    if (hs) begin
      hs_cnt++;
      $display("[TB] beat idx=%0d i=%0d q=%0d last=%0d sat=%0d",
               cur.idx, cur.i, cur.q, cur.last, cur.sat);
    end
    if (ld) begin
      cur = mq.pop_front();
      mv  = 1'b1;
    end else if (hs) begin
      mv = 1'b0;
    end
    if (acc) push_frame();
    exp_drop = v && !acc;
    #1;
    chk("m_valid", int'(m_valid), int'(mv));
    if (mv) begin
      chk("m_i", int'(m_i), cur.i);
      chk("m_q", int'(m_q), cur.q);
      chk("m_index", int'(m_index), cur.idx);
      chk("m_last", int'(m_last), int'(cur.last));
      chk("m_sat", int'(m_sat), int'(cur.sat));
    end
    chk("frame_drop", int'(frame_drop), int'(exp_drop));
    chk("busy", int'(busy), int'((mq.size() > 0) || mv));
    if (frame_drop) begin
      drop_cnt++;
      $display("[TB] frame dropped at %0t", $time);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((mv || mq.size() > 0) && k < budget) begin
      step(1'b0, 1'b1);
      k++;
    end
    chk("drain_idle", int'(busy), 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_m_valid"}, int'(m_valid), 0);
    chk({tag, "_m_i"}, int'(m_i), 0);
    chk({tag, "_m_q"}, int'(m_q), 0);
    chk({tag, "_m_index"}, int'(m_index), 0);
    chk({tag, "_m_last"}, int'(m_last), 0);
    chk({tag, "_m_sat"}, int'(m_sat), 0);
    chk({tag, "_frame_drop"}, int'(frame_drop), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  vec_t tbl [5];
  int   exp_nat [8];
  int   k;

  initial begin
    tbl[0] = '{32767, -32768, 2047, -2048, 1'b1};
    tbl[1] = '{4, 3, 1, 0, 1'b0};
    tbl[2] = '{-4, -5, 0, -1, 1'b0};
    tbl[3] = '{16376, -16384, 2047, -2048, 1'b0};
    tbl[4] = '{16380, -16388, 2047, -2048, 1'b1};
    exp_nat = '{0, 8, 4, 12, 2, 10, 6, 14};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    m_ready  = 1'b0;
    zero_frame(0, 0);
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Natural reorder, first beat one cycle after capture, contiguous beats.
    for (int p = 0; p < 8; p++) begin
      nat_i[brev(p)] = 16 * p;
      nat_q[brev(p)] = -16 * p;
    end
    drive_frame();
    step(1'b1, 1'b1);
    for (int b = 0; b < 8; b++) begin
      step(1'b0, 1'b1);
      chk("reorder_i", int'(m_i), exp_nat[b]);
      chk("reorder_q", int'(m_q), -exp_nat[b]);
      chk("reorder_last", int'(m_last), int'(b == 7));
    end
    drain(20);

    // Rounding / saturation table: value under test sits at natural index 0.
    for (int t = 0; t < 5; t++) begin
      zero_frame(tbl[t].x_i, tbl[t].x_q);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      chk("tbl_i", int'(m_i), tbl[t].e_i);
      chk("tbl_q", int'(m_q), tbl[t].e_q);
      chk("tbl_sat", int'(m_sat), int'(tbl[t].e_sat));
      drain(20);
    end

    // Backpressure: stall 5 cycles while beat 3 is presented.
    rand_frame();
    hs_cnt = 0;
    step(1'b1, 1'b1);
    k = 0;
    while (!(mv && cur.idx == 3) && k < 20) begin
      step(1'b0, 1'b1);
      k++;
    end
    repeat (5) begin
      step(1'b0, 1'b0);
      chk("bp_hold_index", int'(m_index), 3);
    end
    drain(30);
    chk("bp_handshakes", hs_cnt, 8);

    // Ping-pong: three strobes with the sink stalled, third one dropped.
    hs_cnt   = 0;
    drop_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      rand_frame();
      step(1'b1, 1'b0);
    end
    step(1'b0, 1'b0);
    chk("pp_drop_pulses", drop_cnt, 1);
    k = 0;
    while ((mv || mq.size() > 0) && k < 40) begin
      step(1'b0, 1'b1);
      k++;
    end
    chk("pp_cycles", k, 16);
    chk("pp_handshakes", hs_cnt, 16);
    drain(10);

    // Reset while beat 4 is presented and a second frame is queued.
    rand_frame();
    step(1'b1, 1'b1);
    rand_frame();
    step(1'b1, 1'b1);
    k = 0;
    while (!(mv && cur.idx == 4) && k < 20) begin
      step(1'b0, 1'b1);
      k++;
    end
    chk("rst_at_beat4", int'(m_index), 4);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    mq.delete();
    mv = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) step(1'b0, 1'b1);
    rand_frame();
    hs_cnt = 0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("post_rst_index0", int'(m_index), 0);
    drain(20);
    chk("post_rst_handshakes", hs_cnt, 8);

    // Random strobes and backpressure against the model.
    for (int c = 0; c < 600; c++) begin
      bit v;
      v = ($urandom_range(0, 5) == 0);
      if (v) rand_frame();
      step(v, $urandom_range(0, 3) != 0);
    end
    drain(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
